// File: rtl/mult_arbiter.sv
// Shared signed 16x16 multiplier with round-robin arbitration among N_REQ requesters.
// Grant in T, scaled product and one-hot owner tag registered out in T+2.
module mult_arbiter #(
  parameter int N_REQ = 4,
  parameter int SHIFT = 4,
  parameter int SAT   = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [16*N_REQ-1:0] op_a,
  input  logic [16*N_REQ-1:0] op_b,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   rsp_valid,
  output logic [15:0]        rsp_data,
  output logic               busy,
  output logic [15:0]        op_count
);

  localparam int PW = $clog2(N_REQ);

  logic [PW-1:0]       r_ptr;
  logic                r_s1_v;
  logic [N_REQ-1:0]    r_s1_tag;
  logic signed [15:0]  r_s1_a;
  logic signed [15:0]  r_s1_b;
  logic                r_s2_v;
  logic [N_REQ-1:0]    r_rsp_valid;
  logic [15:0]         r_rsp_data;
  logic [15:0]         r_cnt;

  logic [N_REQ-1:0]    w_gnt;
  logic [PW-1:0]       w_idx;
  logic [PW-1:0]       w_j;
  logic [PW:0]         w_sum;
  logic                w_hit;
  logic                w_any;
  logic [PW-1:0]       w_ptr_nxt;
  logic signed [31:0]  w_prod;
  logic signed [31:0]  w_sh;
  logic                w_hi;
  logic                w_lo;
  logic [15:0]         w_res;

  // Scan upward from the pointer, wrapping; first asserted request wins.
  always_comb begin
    w_gnt = '0;
    w_idx = '0;
    w_hit = 1'b0;
    w_sum = '0;
    w_j   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_sum = {1'b0, r_ptr} + (PW+1)'(k);
      if (w_sum >= (PW+1)'(N_REQ))
        w_sum = w_sum - (PW+1)'(N_REQ);
      w_j = w_sum[PW-1:0];
      if (!w_hit && req[w_j]) begin
        w_hit    = 1'b1;
        w_idx    = w_j;
        w_gnt[w_j] = 1'b1;
      end
    end
  end

  assign w_any     = w_hit;
  assign gnt       = reset ? '0 : w_gnt;
  assign w_ptr_nxt = (w_idx == PW'(N_REQ-1)) ? '0 : w_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr    <= '0;
      r_s1_v   <= 1'b0;
      r_s1_tag <= '0;
      r_s1_a   <= '0;
      r_s1_b   <= '0;
      r_cnt    <= '0;
    end else begin
      r_s1_v   <= w_any;
      r_s1_tag <= w_gnt;
      if (w_any) begin
        r_s1_a <= op_a[{w_idx, 4'b0000} +: 16];
        r_s1_b <= op_b[{w_idx, 4'b0000} +: 16];
        r_ptr  <= w_ptr_nxt;
        r_cnt  <= r_cnt + 16'd1;
      end
    end
  end

  assign w_prod = 32'(r_s1_a) * 32'(r_s1_b);
  assign w_sh   = w_prod >>> SHIFT;
  assign w_hi   = w_sh > 32'sd32767;
  assign w_lo   = w_sh < -32'sd32768;

  always_comb begin
    w_res = w_sh[15:0];
    if (SAT != 0 && w_hi)
      w_res = 16'h7FFF;
    else if (SAT != 0 && w_lo)
      w_res = 16'h8000;
  end

  // Output register doubles as pipeline stage 2.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s2_v      <= 1'b0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
    end else begin
      r_s2_v      <= r_s1_v;
      r_rsp_valid <= r_s1_v ? r_s1_tag : '0;
      if (r_s1_v)
        r_rsp_data <= w_res;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign busy      = r_s1_v | r_s2_v;
  assign op_count  = r_cnt;

endmodule

// File: tb/tb_mult_arbiter.sv
// Random and directed bench for mult_arbiter against a queue-based model.
// Two instances (wrap and saturate) share all inputs.
module tb_mult_arbiter;

  localparam int N = 4;
  localparam int SH = 4;

  typedef struct {
    int          due;
    logic [N-1:0] tag;
    logic [15:0] d0;
    logic [15:0] d1;
  } rsp_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [N-1:0]      req = '0;
  logic [16*N-1:0]   op_a;
  logic [16*N-1:0]   op_b;
  logic signed [15:0] a_arr [N];
  logic signed [15:0] b_arr [N];

  logic [N-1:0] gnt0, gnt1, rv0, rv1;
  logic [15:0]  rd0, rd1, cnt0, cnt1;
  logic         busy0, busy1;

  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   m_ptr = 0;
  int   w0 = 0;
  bit   starve = 0;
  logic [15:0] m_cnt = '0;
  logic [15:0] m_d0 = '0;
  logic [15:0] m_d1 = '0;
  rsp_t q [$];

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      op_a[16*i +: 16] = a_arr[i];
      op_b[16*i +: 16] = b_arr[i];
    end
  end

  mult_arbiter #(.N_REQ(N), .SHIFT(SH), .SAT(0)) u_wrap (
    .clk(clk), .reset(reset), .req(req),
    .op_a(op_a), .op_b(op_b), .gnt(gnt0),
    .rsp_valid(rv0), .rsp_data(rd0),
    .busy(busy0), .op_count(cnt0)
  );

  mult_arbiter #(.N_REQ(N), .SHIFT(SH), .SAT(1)) u_sat (
    .clk(clk), .reset(reset), .req(req),
    .op_a(op_a), .op_b(op_b), .gnt(gnt1),
    .rsp_valid(rv1), .rsp_data(rd1),
    .busy(busy1), .op_count(cnt1)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, obs, exp);
    end
  endtask

  // Floor division by 2**SHIFT, then wrap or clamp.
  function automatic logic [15:0] scale(int a, int b, bit sat);
    longint p, d, s;
    p = longint'(a) * longint'(b);
    d = longint'(1) << SH;
    s = p / d;
    if (p < 0 && (p % d) != 0) s = s - 1;
    if (sat) begin
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
    end
    return s[15:0];
  endfunction

  task automatic tick();
    int g;
    int j;
    logic [N-1:0] eg;
    logic [N-1:0] ev;
    rsp_t r;
    @(negedge clk);
    g = -1;
    if (!reset)
      for (int k = 0; k < N; k++) begin
        j = (m_ptr + k) % N;
        if (g < 0 && req[j]) g = j;
      end
    eg = '0;
    if (g >= 0) eg[g] = 1'b1;
    chk("gnt", 32'(gnt0), 32'(eg));
    chk("gnt_sat", 32'(gnt1), 32'(eg));
    chk("busy", 32'(busy0), 32'(q.size() != 0));
    ev = '0;
    if (q.size() != 0 && q[0].due == cyc) begin
      r = q.pop_front();
      ev = r.tag;
      m_d0 = r.d0;
      m_d1 = r.d1;
    end
    chk("rsp_valid", 32'(rv0), 32'(ev));
    chk("rsp_valid_sat", 32'(rv1), 32'(ev));
    chk("rsp_data", 32'(rd0), 32'(m_d0));
    chk("rsp_data_sat", 32'(rd1), 32'(m_d1));
    chk("op_count", 32'(cnt0), 32'(m_cnt));
    if (starve && !reset && req[0]) begin
      w0++;
      if (g == 0) begin
        chk("starve_wait", 32'(w0 <= N), 32'd1);
        w0 = 0;
      end
    end
    if (reset) begin
      q.delete();
      m_ptr = 0;
      m_cnt = '0;
      m_d0 = '0;
      m_d1 = '0;
    end else if (g >= 0) begin
      r.due = cyc + 2;
      r.tag = eg;
      r.d0 = scale(int'(a_arr[g]), int'(b_arr[g]), 1'b0);
      r.d1 = scale(int'(a_arr[g]), int'(b_arr[g]), 1'b1);
      q.push_back(r);
      m_ptr = (g + 1) % N;
      m_cnt = m_cnt + 16'd1;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    req = '0;
    repeat (n) tick();
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      a_arr[i] = '0;
      b_arr[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    req = '1;
    tick();
    reset = 1'b0;

    a_arr[0] = 16'sd10;
    b_arr[0] = -16'sd3;
    req = 4'b0001;
    tick();
    idle(3);

    for (int i = 0; i < N; i++) begin
      a_arr[i] = 16'(i + 1);
      b_arr[i] = 16'sd16;
    end
    req = 4'b1111;
    repeat (5) tick();
    idle(3);

    req = 4'b0100;
    tick();
    req = 4'b1001;
    tick();
    req = 4'b0001;
    tick();
    idle(3);

    a_arr[1] = 16'sd32767;
    b_arr[1] = 16'sd32767;
    a_arr[2] = -16'sd32768;
    b_arr[2] = -16'sd32768;
    req = 4'b0010;
    tick();
    req = 4'b0100;
    tick();
    idle(3);

    req = 4'b0001;
    tick();
    req = '0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle(4);

    reset = 1'b1;
    req = 4'b0011;
    tick();
    reset = 1'b0;
    idle(2);

    starve = 1;
    w0 = 0;
    for (int c = 0; c < 1000; c++) begin
      for (int i = 0; i < N; i++) begin
        a_arr[i] = 16'($urandom);
        b_arr[i] = 16'($urandom);
      end
      req = {3'($urandom), 1'b1};
      tick();
    end
    starve = 0;
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
